// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among N_REQ requesters.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module fifo_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        ovalid,
    output logic [DATA_WIDTH-1:0]       odata,
    output logic [ID_WIDTH-1:0]         oid,
    input  logic                        oready,
    output logic                        busy,
    output logic [ID_WIDTH-1:0]         grant_id
);

    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_ovalid;
    logic [DATA_WIDTH-1:0] r_odata;
    logic [ID_WIDTH-1:0]   r_oid;

    logic                  w_scan_hit;
    logic [ID_WIDTH-1:0]   w_scan_id;
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_grant;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_release;
    int                    w_start;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    assign w_start = 0;
`else
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   w_next_ptr;

    assign w_start    = int'(r_rr_ptr);
    assign w_next_ptr = (r_grant_id == ID_WIDTH'(N_REQ - 1)) ?
                        '0 : r_grant_id + 1'b1;
`endif

    // First valid requester at or after the scan start, wrapping
    always_comb begin
        int v_idx;
        w_scan_hit = 1'b0;
        w_scan_id  = '0;
        v_idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            v_idx = w_start + i;
            if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
            if (!w_scan_hit && req_valid[v_idx]) begin
                w_scan_hit = 1'b1;
                w_scan_id  = ID_WIDTH'(v_idx);
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_WIDTH'(i) == r_grant_id) begin
                w_sel_valid = req_valid[i];
                w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_grant     = (r_state == S_GRANT);
    assign w_slot_free = !r_ovalid || oready;
    assign w_accept    = w_grant && w_slot_free && w_sel_valid;
    assign w_last      = (r_beat_cnt == CW'(BURST_LEN - 1));
    assign w_release   = w_grant && w_slot_free &&
                         (!w_sel_valid || w_last);

    // Ready depends only on grant state and output slot, never on req_valid
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant && w_slot_free && ID_WIDTH'(i) == r_grant_id)
                req_ready[i] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_scan_hit) w_state_nxt = S_GRANT;
            S_GRANT: if (w_release)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_ovalid   <= 1'b0;
            r_odata    <= '0;
            r_oid      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_scan_hit) begin
                r_grant_id <= w_scan_id;
                r_beat_cnt <= '0;
            end
            if (w_accept) begin
                r_odata    <= w_sel_data;
                r_oid      <= r_grant_id;
                r_ovalid   <= 1'b1;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end else if (oready) begin
                r_ovalid <= 1'b0;
            end
        end
    end

`ifndef FIFO_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rr_ptr <= '0;
        else if (w_release)
            r_rr_ptr <= w_next_ptr;
    end
`endif

    assign ovalid   = r_ovalid;
    assign odata    = r_odata;
    assign oid      = r_oid;
    assign busy     = w_grant;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed self-checking bench for fifo_rr_arbiter (N_REQ=4, BURST_LEN=4).
// Requesters are modelled as counters streaming base+pos on each handshake.
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ovalid;
    logic [7:0]  odata;
    logic [1:0]  oid;
    logic        oready;
    logic        busy;
    logic [1:0]  grant_id;

    int          n_chk = 0;
    int          n_err = 0;
    int          pos  [4];
    int          cnt  [4];
    logic        en   [4];
    logic [7:0]  base [4];

    fifo_rr_arbiter #(
        .N_REQ      (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ovalid    (ovalid),
        .odata     (odata),
        .oid       (oid),
        .oready    (oready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = en[i] && (pos[i] < cnt[i]);
            req_data[i*8 +: 8] = base[i] + 8'(pos[i]);
        end
    endtask

    // One clock: record handshakes before the edge, advance producers after
    task automatic tick();
        logic [3:0] hs;
        #2;
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i]) pos[i]++;
        drive();
        #1;
    endtask

    task automatic clr_src();
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0; pos[i] = 0; cnt[i] = 0; base[i] = 8'h00;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        oready = 1'b1;
        clr_src();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n  = 1'b0;
        oready = 1'b1;
        clr_src();
        #7;
        chk("rst_ovalid", 32'(ovalid), 0);
        chk("rst_odata", 32'(odata), 0);
        chk("rst_oid", 32'(oid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

`ifdef FIFO_ARB_FIXED_PRIO_EN
        en[0] = 1'b1; base[0] = 8'h00; cnt[0] = 12;
        en[3] = 1'b1; base[3] = 8'h30; cnt[3] = 16;
        drive();
        for (int b = 0; b < 3; b++) begin
            tick();
            chk("fp_gid", 32'(grant_id), 0);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("fp_oid", 32'(oid), 0);
                chk("fp_data", 32'(odata), 32'(b * 4 + k));
            end
        end
        tick();
        chk("fp_gid3", 32'(grant_id), 3);
        tick();
        chk("fp_data3", 32'(odata), 32'h30);
`else
        // Single requester 2 streaming six beats
        en[2] = 1'b1; base[2] = 8'h10; cnt[2] = 6;
        drive();
        tick();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_gid", 32'(grant_id), 2);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_ovalid", 32'(ovalid), 1);
            chk("t1_data", 32'(odata), 32'(8'h10 + k));
            chk("t1_oid", 32'(oid), 2);
        end
        chk("t1_rel", 32'(busy), 0);
        tick();
        chk("t1_bubble", 32'(ovalid), 0);
        chk("t1_regrant", 32'(busy), 1);
        for (int k = 4; k < 6; k++) begin
            tick();
            chk("t1_data2", 32'(odata), 32'(8'h10 + k));
        end
        chk("t1_busy_hold", 32'(busy), 1);
        tick();
        chk("t1_busy_drop", 32'(busy), 0);
        chk("t1_drain", 32'(ovalid), 0);

        // All four always valid: full bursts rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b1; base[i] = 8'(i << 4); cnt[i] = 16;
        end
        drive();
        for (int b = 0; b < 5; b++) begin
            tick();
            chk("t2_gid", 32'(grant_id), 32'(b % 4));
            chk("t2_bubble", 32'(ovalid), 0);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("t2_oid", 32'(oid), 32'(b % 4));
                chk("t2_data", 32'(odata),
                    32'(((b % 4) << 4) + (b / 4) * 4 + k));
            end
        end

        // Backpressure mid-burst from requester 1
        do_reset();
        en[1] = 1'b1; base[1] = 8'h20; cnt[1] = 8;
        drive();
        tick();
        tick();
        chk("t3_first", 32'(odata), 32'h20);
        oready = 1'b0;
        #1;
        chk("t3_rdy0", 32'(req_ready), 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_ovalid", 32'(ovalid), 1);
            chk("t3_data", 32'(odata), 32'h20);
            chk("t3_rdy", 32'(req_ready), 0);
            chk("t3_gid", 32'(grant_id), 1);
            chk("t3_busy", 32'(busy), 1);
            if (c == 1) begin
                en[1] = 1'b0;
                drive();
            end
        end
        oready = 1'b1;
        tick();
        chk("t3_rel", 32'(busy), 0);
        chk("t3_drain", 32'(ovalid), 0);
        en[1] = 1'b1;
        en[2] = 1'b1; base[2] = 8'h30; cnt[2] = 8;
        drive();
        tick();
        chk("t3_ptr2", 32'(grant_id), 2);

        // Short burst from requester 3, then wrap to 0
        do_reset();
        en[3] = 1'b1; base[3] = 8'h40; cnt[3] = 2;
        drive();
        tick();
        chk("t4_gid", 32'(grant_id), 3);
        tick();
        chk("t4_d0", 32'(odata), 32'h40);
        chk("t4_oid", 32'(oid), 3);
        tick();
        chk("t4_d1", 32'(odata), 32'h41);
        en[0] = 1'b1; base[0] = 8'h50; cnt[0] = 8;
        drive();
        tick();
        chk("t4_rel", 32'(busy), 0);
        tick();
        chk("t4_wrap", 32'(grant_id), 0);

        // Asynchronous reset while a beat sits in the output register
        tick();
        chk("t5_pre", 32'(ovalid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_ovalid", 32'(ovalid), 0);
        chk("t5_odata", 32'(odata), 0);
        chk("t5_oid", 32'(oid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_gid", 32'(grant_id), 0);
        chk("t5_ready", 32'(req_ready), 0);
        clr_src();
        en[1] = 1'b1; base[1] = 8'h60; cnt[1] = 4;
        en[3] = 1'b1; base[3] = 8'h70; cnt[3] = 4;
        drive();
        #1;
        rst_n = 1'b1;
        tick();
        chk("t5_gid1", 32'(grant_id), 1);
        chk("t5_noout", 32'(ovalid), 0);
        tick();
        chk("t5_data", 32'(odata), 32'h60);
        chk("t5_oid1", 32'(oid), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
